// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
package uio_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        TURN,
        RDATA
    } arb_state_t;

    localparam int REQ_IF     = 0;
    localparam int REQ_LS     = 1;
    localparam int TURN_CNT_W = 3;

    localparam logic [7:0] OE_DRIVE   = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;

endpackage

// File: rtl/uio_arb_pick.sv
// Two-way winner select; round-robin when UIO_ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with load/store ahead of fetch.
module uio_arb_pick
    import uio_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] win
);

`ifdef UIO_ARB_ROUND_ROBIN_EN
    // Reset to "load/store went last" so fetch wins the first contest.
    logic last_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ls <= 1'b1;
        end else if (take) begin
            last_ls <= win[REQ_LS];
        end
    end

    always_comb begin
        win = req;
        if (&req) begin
            win = last_ls ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_pick;
    assign unused_pick = &{1'b0, clk, rst, take};

    always_comb begin
        win = req;
        if (req[REQ_LS]) begin
            win[REQ_IF] = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uio_mem_arbiter.sv
// Arbitrates fetch and load/store onto the uio pads: address, optional turnaround, data.
// Arbitration policy selected by UIO_ARB_ROUND_ROBIN_EN (see uio_arb_pick).
module uio_mem_arbiter
    import uio_arb_pkg::*;
#(
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req,
    input  logic       ls_req,
    input  logic [7:0] if_addr,
    input  logic [7:0] ls_addr,
    input  logic       ls_we,
    input  logic [7:0] ls_wdata,
    output logic       if_gnt,
    output logic       ls_gnt,
    output logic       if_done,
    output logic       ls_done,
    output logic [7:0] rdata,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic [7:0] uio_in,
    output logic       mem_ale,
    output logic       mem_we,
    output logic       mem_re
);

    localparam logic [TURN_CNT_W-1:0] TURN_LAST =
        TURN_CNT_W'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);

    arb_state_t            state;
    logic [TURN_CNT_W-1:0] turn_cnt;
    logic                  owner_ls;
    logic                  lat_we;
    logic [7:0]            lat_wdata;

    logic [1:0] req;
    logic [1:0] win;
    logic [1:0] gnt;
    logic       take;

    assign req    = {ls_req, if_req};
    assign take   = (state == IDLE) && (|req) && !rst;
    assign gnt    = take ? win : 2'b00;
    assign if_gnt = gnt[REQ_IF];
    assign ls_gnt = gnt[REQ_LS];

    uio_arb_pick u_pick (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .take (take),
        .win  (win)
    );

    // Pad outputs are registered one state ahead so they change only on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            turn_cnt  <= '0;
            owner_ls  <= 1'b0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            rdata     <= '0;
            uio_out   <= '0;
            uio_oe    <= OE_RELEASE;
            mem_ale   <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        owner_ls  <= win[REQ_LS];
                        lat_we    <= win[REQ_LS] & ls_we;
                        lat_wdata <= ls_wdata;
                        uio_out   <= win[REQ_LS] ? ls_addr : if_addr;
                        uio_oe    <= OE_DRIVE;
                        mem_ale   <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    mem_ale <= 1'b0;
                    if (lat_we) begin
                        uio_out <= lat_wdata;
                        mem_we  <= 1'b1;
                        state   <= WDATA;
                    end else begin
                        uio_out  <= '0;
                        uio_oe   <= OE_RELEASE;
                        mem_re   <= 1'b1;
                        turn_cnt <= TURN_LAST;
                        state    <= (TURN_CYCLES > 0) ? TURN : RDATA;
                    end
                end
                WDATA: begin
                    uio_out <= '0;
                    uio_oe  <= OE_RELEASE;
                    mem_we  <= 1'b0;
                    if_done <= !owner_ls;
                    ls_done <= owner_ls;
                    state   <= IDLE;
                end
                TURN: begin
                    if (turn_cnt == '0) begin
                        state <= RDATA;
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
                RDATA: begin
                    rdata   <= uio_in;
                    mem_re  <= 1'b0;
                    if_done <= !owner_ls;
                    ls_done <= owner_ls;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uio_mem_arbiter.sv
// Four arbiters (TURN_CYCLES 1,0,3,7) under directed then random traffic, checked
// against a transaction-timeline model and an external-memory model on the pads.
module tb_uio_mem_arbiter;

    localparam int NL = 4;

    typedef struct {
        int         port;
        bit         we;
        logic [7:0] rd;
        int         cyc;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       if_req   [NL];
    logic       ls_req   [NL];
    logic [7:0] if_addr  [NL];
    logic [7:0] ls_addr  [NL];
    logic       ls_we    [NL];
    logic [7:0] ls_wdata [NL];
    logic       if_gnt   [NL];
    logic       ls_gnt   [NL];
    logic       if_done  [NL];
    logic       ls_done  [NL];
    logic [7:0] rdata    [NL];
    logic [7:0] uio_out  [NL];
    logic [7:0] uio_oe   [NL];
    logic [7:0] uio_in   [NL];
    logic       mem_ale  [NL];
    logic       mem_we   [NL];
    logic       mem_re   [NL];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    rec_t       sb      [NL][$];
    bit         act     [NL];
    int         st      [NL];
    int         dn      [NL];
    bit         tw      [NL];
    logic [7:0] ta      [NL];
    logic [7:0] td      [NL];
    bit         last_ls [NL];
    logic [7:0] ref_mem [NL][256];
    // External memory device on the pads
    logic [7:0] dev_mem [NL][256];
    logic [7:0] dev_addr[NL];
    int         dev_cnt [NL];

    function automatic int lane_t(input int l);
        case (l)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 7;
        endcase
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_dut
        localparam int TG = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
        uio_mem_arbiter #(.TURN_CYCLES(TG)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req[g]),
            .ls_req   (ls_req[g]),
            .if_addr  (if_addr[g]),
            .ls_addr  (ls_addr[g]),
            .ls_we    (ls_we[g]),
            .ls_wdata (ls_wdata[g]),
            .if_gnt   (if_gnt[g]),
            .ls_gnt   (ls_gnt[g]),
            .if_done  (if_done[g]),
            .ls_done  (ls_done[g]),
            .rdata    (rdata[g]),
            .uio_out  (uio_out[g]),
            .uio_oe   (uio_oe[g]),
            .uio_in   (uio_in[g]),
            .mem_ale  (mem_ale[g]),
            .mem_we   (mem_we[g]),
            .mem_re   (mem_re[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int l, input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL lane%0d %s cyc=%0d got=%h expected=%h", l, nm, cyc, got, exp);
        end
    endtask

    // Spec arbitration rule: 2'b{ls,if}
    function automatic logic [1:0] model_pick(input logic i, input logic s, input bit prev_ls);
        if (i && s) begin
`ifdef UIO_ARB_ROUND_ROBIN_EN
            return prev_ls ? 2'b01 : 2'b10;
`else
            return 2'b10;
`endif
        end
        return {s, i};
    endfunction

    task automatic check_lane(input int l);
        logic [18:0] exp_pad, got_pad;
        logic [1:0]  exp_g, got_g, got_d;
        int          k;
        bit          idle;
        rec_t        r;
        got_pad = {uio_oe[l], uio_out[l], mem_ale[l], mem_we[l], mem_re[l]};
        got_g   = {ls_gnt[l], if_gnt[l]};
        got_d   = {ls_done[l], if_done[l]};
        if (rst) begin
            check(l, "reset_outputs", {got_pad, got_g, got_d, rdata[l]}, 64'd0);
            sb[l].delete();
            act[l]     = 1'b0;
            last_ls[l] = 1'b1;
            return;
        end
        exp_pad = '0;
        if (act[l] && cyc < dn[l]) begin
            k = cyc - st[l];
            if (k == 1)      exp_pad = {8'hFF, ta[l], 3'b100};
            else if (tw[l])  exp_pad = {8'hFF, td[l], 3'b010};
            else if (k >= 2) exp_pad = {8'h00, 8'h00, 3'b001};
        end
        check(l, "pads", got_pad, exp_pad);

        if (got_d != 2'b00) begin
            if (sb[l].size() == 0) begin
                check(l, "done_spurious", got_d, 2'b00);
            end else begin
                r = sb[l].pop_front();
                check(l, "done_port", got_d, (r.port == 1) ? 2'b10 : 2'b01);
                check(l, "done_cycle", cyc, r.cyc);
                if (!r.we) check(l, "rdata", rdata[l], r.rd);
            end
        end else if (sb[l].size() > 0 && sb[l][0].cyc < cyc) begin
            check(l, "done_late", cyc, sb[l][0].cyc);
            void'(sb[l].pop_front());
        end

        idle  = !act[l] || cyc >= dn[l];
        exp_g = idle ? model_pick(if_req[l], ls_req[l], last_ls[l]) : 2'b00;
        check(l, "gnt", got_g, exp_g);
        if (exp_g != 2'b00) begin
            r.port  = exp_g[1] ? 1 : 0;
            r.we    = exp_g[1] && ls_we[l];
            ta[l]   = exp_g[1] ? ls_addr[l] : if_addr[l];
            td[l]   = ls_wdata[l];
            r.rd    = ref_mem[l][ta[l]];
            if (r.we) ref_mem[l][ta[l]] = td[l];
            r.cyc   = cyc + (r.we ? 3 : 3 + lane_t(l));
            tw[l]   = r.we;
            act[l]  = 1'b1;
            st[l]   = cyc;
            dn[l]   = r.cyc;
            last_ls[l] = exp_g[1];
            sb[l].push_back(r);
        end

        // Memory device: data is valid only in the final read-strobe cycle.
        if (mem_ale[l]) begin
            dev_addr[l] = uio_out[l];
            dev_cnt[l]  = 0;
        end else begin
            dev_cnt[l]++;
        end
        if (mem_we[l]) dev_mem[l][dev_addr[l]] = uio_out[l];
        uio_in[l] = (mem_re[l] && dev_cnt[l] == lane_t(l) + 1) ? dev_mem[l][dev_addr[l]]
                                                               : 8'($urandom);
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) check_lane(l);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int p, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (p == 1) ? ls_gnt[0] : if_gnt[0];
        end
        check(0, nm, seen, 1);
    endtask

    task automatic new_req(input int l, input int p);
        if (p == 0) begin
            if_req[l]  = 1'b1;
            if_addr[l] = 8'($urandom_range(0, 15));
        end else begin
            ls_req[l]   = 1'b1;
            ls_addr[l]  = 8'($urandom_range(0, 15));
            ls_we[l]    = 1'($urandom_range(0, 1));
            ls_wdata[l] = 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_ord [4];
        logic [1:0] g_if [NL];
        logic [1:0] g_ls [NL];
        int got;
        int cnt;
        for (int l = 0; l < NL; l++) begin
            if_req[l] = 0; ls_req[l] = 0; if_addr[l] = 0; ls_addr[l] = 0;
            ls_we[l] = 0; ls_wdata[l] = 0; uio_in[l] = 0;
            act[l] = 0; last_ls[l] = 1; dev_addr[l] = 0; dev_cnt[l] = 0;
            for (int i = 0; i < 256; i++) begin
                ref_mem[l][i] = 8'(i * 37 + l * 11 + 1);
                dev_mem[l][i] = 8'(i * 37 + l * 11 + 1);
            end
        end
        ref_mem[0][8'h3C] = 8'hA5;
        dev_mem[0][8'h3C] = 8'hA5;
`ifdef UIO_ARB_ROUND_ROBIN_EN
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_ord = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single fetch read of 0x3C
        step();
        if_req[0] = 1; if_addr[0] = 8'h3C;
        wait_gnt(0, "fetch_gnt");
        step();
        if_req[0] = 0;
        repeat (8) step();

        // Load/store write 0x10 <= 0x5A
        ls_req[0] = 1; ls_we[0] = 1; ls_addr[0] = 8'h10; ls_wdata[0] = 8'h5A;
        wait_gnt(1, "ls_write_gnt");
        step();
        ls_req[0] = 0;
        repeat (6) step();

        // Both ports requesting continuously
        if_req[0] = 1; if_addr[0] = 8'h20;
        ls_req[0] = 1; ls_we[0] = 0; ls_addr[0] = 8'h21;
        got = 0;
        for (int i = 0; i < 200 && got < 4; i++) begin
            @(negedge clk);
            #1;
            if (if_gnt[0] || ls_gnt[0]) begin
                check(0, "arb_order", {ls_gnt[0], if_gnt[0]}, exp_ord[got]);
                got++;
            end
        end
        check(0, "arb_count", got, 4);
        step();
        if_req[0] = 0; ls_req[0] = 0;
        repeat (10) step();

        // Reset pulsed during WDATA
        ls_req[0] = 1; ls_we[0] = 1; ls_addr[0] = 8'h44; ls_wdata[0] = 8'h99;
        wait_gnt(1, "rst_case_gnt");
        step();
        ls_req[0] = 0;
        step();
        check(0, "wdata_phase", {uio_oe[0], mem_we[0]}, {8'hFF, 1'b1});
        #1 rst = 1'b1;
        #1 check(0, "rst_async_pads", {uio_oe[0], mem_we[0]}, 9'd0);
        step();
        rst = 1'b0;
        ls_req[0] = 1; ls_we[0] = 0; ls_addr[0] = 8'h45;
        @(negedge clk);
        #1 check(0, "gnt_after_rst", ls_gnt[0], 1);
        step();
        ls_req[0] = 0;
        repeat (10) step();

        // Fetch request withdrawn while load/store busy
        ls_req[0] = 1; ls_we[0] = 1; ls_addr[0] = 8'h50; ls_wdata[0] = 8'h3E;
        wait_gnt(1, "withdraw_ls_gnt");
        step();
        ls_req[0] = 0; if_req[0] = 1; if_addr[0] = 8'h77;
        step();
        if_req[0] = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (if_gnt[0]) cnt++;
        end
        check(0, "withdraw_no_gnt", cnt, 0);
        step();

        // Random traffic on all lanes
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            for (int l = 0; l < NL; l++) begin
                g_if[l] = {1'b0, if_gnt[l]};
                g_ls[l] = {1'b0, ls_gnt[l]};
            end
            step();
            for (int l = 0; l < NL; l++) begin
                if (if_req[l]) begin
                    if (g_if[l][0]) begin
                        if ($urandom_range(0, 1) == 1) new_req(l, 0); else if_req[l] = 0;
                    end else if ($urandom_range(0, 19) == 0) begin
                        if_req[l] = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(l, 0);
                end
                if (ls_req[l]) begin
                    if (g_ls[l][0]) begin
                        if ($urandom_range(0, 1) == 1) new_req(l, 1); else ls_req[l] = 0;
                    end else if ($urandom_range(0, 19) == 0) begin
                        ls_req[l] = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(l, 1);
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            if_req[l] = 0;
            ls_req[l] = 0;
        end
        repeat (40) step();
        for (int l = 0; l < NL; l++) check(l, "drain_outstanding", sb[l].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uio_mem_arbiter.md
# uio_mem_arbiter

Shares the 8-bit bidirectional `uio` pad bus between the CPU's instruction-fetch port and its load/store port. It runs a multi-cycle external-memory transaction on the pads: address phase, bus turnaround, then a data phase. The block sits between the CPU core and the `uio_out`/`uio_oe`/`uio_in` pins inside `tt_um_simple_cpu`. It owns `uio_oe` completely, so neither CPU port ever drives the pads directly.

## Interface
Parameters:
- `TURN_CYCLES`, default 1: idle cycles between address phase and read sample, with pads released. Legal range 0..7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`, `ls_req`  in  1  request from fetch (0) or load/store (1).
- `if_addr`, `ls_addr`  in  8  transaction address.
- `ls_we`  in  1  load/store direction: 1 = write, 0 = read. Fetch is always a read.
- `ls_wdata`  in  8  write data.
- `if_gnt`, `ls_gnt`  out  1  one-cycle pulse when the request is accepted.
- `if_done`, `ls_done`  out  1  one-cycle pulse when the transaction completes.
- `rdata`  out  8  read data, valid while a `*_done` of a read is high.
- `uio_out`  out  8  pad output data.
- `uio_oe`  out  8  pad output enable; `8'hFF` or `8'h00` only.
- `uio_in`  in  8  pad input data.
- `mem_ale`  out  1  address latch enable.
- `mem_we`  out  1  write strobe.
- `mem_re`  out  1  read strobe.

## Operation
- FSM states: IDLE, ADDR, WDATA, TURN, RDATA.
- IDLE:
  - If any request is high, pick a winner and pulse its `*_gnt` in that same cycle.
  - Latch `addr`, `we` and `wdata` from the winner, then go to ADDR.
- ADDR: `uio_oe=FF`, `uio_out=addr`, `mem_ale=1`.
  - If `we`, next state is WDATA.
  - Else, if `TURN_CYCLES>0`, next state is TURN; otherwise RDATA.
- WDATA: `uio_oe=FF`, `uio_out=wdata`, `mem_we=1`. Next state is IDLE; pulse the owner's `*_done` in the next cycle.
- TURN: `uio_oe=00`, `mem_re=1`. A 3-bit counter holds the FSM here for `TURN_CYCLES` cycles, then it moves to RDATA.
- RDATA: `uio_oe=00`, `mem_re=1`. Register `uio_in` into `rdata` at the clock edge leaving this state. Next state is IDLE; `*_done` pulses with `rdata` valid.
- Outside ADDR and WDATA, `uio_out` is `8'h00`.
- Pad outputs and strobes are decoded only from the state register and latched fields. They are glitch-free and never depend combinationally on request inputs.
- Request rule: a requester holds `req`, `addr` and `wdata` stable until `gnt`. It may drop `req` before `gnt` to withdraw the request. `req` still high after `gnt` counts as a new request.
- Simultaneous requests in IDLE are resolved by the arbitration policy (see Configuration). Exactly one `gnt` per accepted transaction.
- A request arriving while the FSM is busy waits; it is not lost as long as it is held.
- The cycle in which `*_done` pulses is IDLE, so a new grant can issue in that same cycle.

## Timing
- Reset values:
  - State IDLE; all `*_gnt`, `*_done` and strobes 0.
  - `uio_oe=00`, `uio_out=00`, `rdata=00`.
  - Round-robin pointer set so fetch has priority.
- Reset asserted mid-transaction:
  - Outputs return to reset values asynchronously; `uio_oe` drops immediately.
  - No `*_done` for the aborted transaction.
- Latency, with `gnt` at cycle 0:
  - Write: ADDR at cycle 1, WDATA at cycle 2, `done` at cycle 3.
  - Read: ADDR at cycle 1, TURN at cycles 2..1+T, RDATA at cycle 2+T, `done` at cycle 3+T.
- Back-to-back throughput:
  - Writes: one per 3 cycles.
  - Reads: one per 3+T cycles.
- With `TURN_CYCLES=0`, the pads are released in RDATA in the same cycle the sample is taken. External memory must tolerate this.

## Configuration
- `UIO_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration with a 1-bit last-grant pointer.
  - On a simultaneous request, the port not granted last wins.
  - The pointer updates on every grant.
- `UIO_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: load/store beats fetch.
  - No pointer flop exists.

## Structure
- Package `uio_arb_pkg`:
  - State enum.
  - Requester index constants `REQ_IF=0` and `REQ_LS=1`.
  - `TURN_CNT_W=3`.
  - Pad constants `OE_DRIVE=8'hFF` and `OE_RELEASE=8'h00`.
- Sub-module `uio_arb_pick`:
  - Takes the request vector; returns the one-hot winner.
  - Holds the round-robin pointer when the feature macro is enabled.

## Test plan
- Single fetch read, `addr=8'h3C`, `TURN_CYCLES=1`, `uio_in=8'hA5` during RDATA → `if_gnt` at cycle 0, `mem_ale` with `uio_out=3C` at cycle 1, `uio_oe=00` at cycles 2–3, `if_done` with `rdata=A5` at cycle 4.
- Load/store write, `addr=8'h10`, `wdata=8'h5A` → `uio_out=10` then `uio_out=5A` with `uio_oe=FF` and `mem_we=1`, then `ls_done` at cycle 3.
- Both ports requesting continuously, four grants:
  - Fixed priority: LS,LS,LS,LS.
  - With `UIO_ARB_ROUND_ROBIN_EN`: IF,LS,IF,LS.
- Sweep `TURN_CYCLES` over 0, 3, 7 → read `done` lands at cycle 3+T; `uio_oe` is never FF during TURN or RDATA.
- `rst` pulsed during WDATA → `uio_oe=00` before the next clock edge, no `ls_done`, and the FSM grants a fresh request one cycle after reset release.
- Fetch `req` dropped before grant while a load/store transaction is in flight → no `if_gnt` and no transaction is issued for it.
